// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller and the
// registers it drives.
//   state_e          : controller FSM state encoding
//   REG_W            : architectural register-index width
//   MUL_CNT_W        : width of the multiply occupancy down-counter
//   WR_LOAD/WR_HOLD  : write-hold polarity seen by the IF/ID and PC registers
package hazard_stall_ctrl_pkg;

    typedef enum logic {
        S_RUN = 1'b0,
        S_MUL = 1'b1
    } state_e;

    localparam int REG_W     = 5;
    localparam int MUL_CNT_W = 4;

    // A '1' on a write-hold input freezes the register.
    localparam logic WR_LOAD = 1'b0;
    localparam logic WR_HOLD = 1'b1;

endpackage : hazard_stall_ctrl_pkg

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/stall controller.
//   master : pipeline side, drives the ID/EX observation fields and receives
//            the hold/bubble/flush controls and the stall counter.
//   slave  : controller side.
interface hazard_stall_ctrl_if
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic [REG_W-1:0] ID_Rs_In;
    logic [REG_W-1:0] ID_Rt_In;
    logic             ID_UsesRt_In;
    logic             ID_MulStart_In;
    logic             ID_BranchTaken_In;
    logic             EX_MemRead_In;
    logic [REG_W-1:0] EX_Rt_In;

    logic             IF_IDWrite_Out;
    logic             PCWrite_Out;
    logic             ID_EX_Bubble_Out;
    logic             IF_Flush_Out;
    logic             Busy_Out;
    logic [CNT_W-1:0] Stall_Count_Out;

    modport master (
        output ID_Rs_In, ID_Rt_In, ID_UsesRt_In, ID_MulStart_In,
               ID_BranchTaken_In, EX_MemRead_In, EX_Rt_In,
        input  IF_IDWrite_Out, PCWrite_Out, ID_EX_Bubble_Out, IF_Flush_Out,
               Busy_Out, Stall_Count_Out
    );

    modport slave (
        input  ID_Rs_In, ID_Rt_In, ID_UsesRt_In, ID_MulStart_In,
               ID_BranchTaken_In, EX_MemRead_In, EX_Rt_In,
        output IF_IDWrite_Out, PCWrite_Out, ID_EX_Bubble_Out, IF_Flush_Out,
               Busy_Out, Stall_Count_Out
    );

endinterface : hazard_stall_ctrl_if

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter: increments on each rising edge with en_i high and
// sticks at all-ones instead of wrapping.
//   clk, reset : clock and asynchronous active-high reset
//   en_i       : count enable
//   count_o    : current count
module hazard_stall_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples its _d value from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : hazard_stall_ctrl_sat_counter

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the IF/ID/EX front end.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of hazard_stall_ctrl_if
//                inputs  - ID rs/rt/uses-rt/mul-start/branch-taken,
//                          EX mem-read and load destination
//                outputs - IF/ID hold, PC hold, ID/EX bubble, IF flush,
//                          multiply busy, saturating stall-cycle count
// Load-use hazards stall one cycle; a multiply holds the front end for
// MUL_LAT-1 cycles after it issues; a taken branch flushes IF unless the
// front end is stalled.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus
);

    if (MUL_LAT < 2 || MUL_LAT > 16) begin : g_bad_mul_lat
        $error("hazard_stall_ctrl: MUL_LAT must lie in 2..16");
    end

    // The issue cycle itself is not a stall and the count runs down to zero
    // inclusive, so loading MUL_LAT-2 yields MUL_LAT-1 stall cycles.
    localparam logic [MUL_CNT_W-1:0] MUL_CNT_INIT = MUL_CNT_W'(MUL_LAT - 2);

    state_e                 state_q;
    state_e                 state_d;
    logic [MUL_CNT_W-1:0]   mul_cnt_q;
    logic [MUL_CNT_W-1:0]   mul_cnt_d;

    logic in_mul;
    logic load_use;
    logic stall;
    logic mul_start;

    assign in_mul = (state_q == S_MUL);

    // Register 0 is hard-wired, so a load targeting it never creates a
    // dependency. rt only matters when the ID instruction reads it.
    assign load_use = bus.EX_MemRead_In
                    && (bus.EX_Rt_In != '0)
                    && ((bus.EX_Rt_In == bus.ID_Rs_In)
                        || (bus.ID_UsesRt_In && (bus.EX_Rt_In == bus.ID_Rt_In)));

    assign stall = in_mul || load_use;

    // A multiply held in ID by a stall only issues once the stall clears.
    assign mul_start = !stall && bus.ID_MulStart_In;

    assign bus.IF_IDWrite_Out   = stall ? WR_HOLD : WR_LOAD;
    assign bus.PCWrite_Out      = stall ? WR_HOLD : WR_LOAD;
    assign bus.ID_EX_Bubble_Out = stall;
    // A stalled branch is re-evaluated when the pipeline advances.
    assign bus.IF_Flush_Out     = !stall && bus.ID_BranchTaken_In;
    assign bus.Busy_Out         = in_mul;

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            S_RUN: begin
                if (mul_start) begin
                    state_d   = S_MUL;
                    mul_cnt_d = MUL_CNT_INIT;
                end
            end
            S_MUL: begin
                if (mul_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    hazard_stall_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (stall),
        .count_o (bus.Stall_Count_Out)
    );

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int LAT_A = 4;
    localparam int CNT_A = 32;
    localparam int LAT_B = 2;
    localparam int CNT_B = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(CNT_A)) bus_a ();
    hazard_stall_ctrl_if #(.CNT_W(CNT_B)) bus_b ();

    hazard_stall_ctrl #(.MUL_LAT(LAT_A), .CNT_W(CNT_A)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    hazard_stall_ctrl #(.MUL_LAT(LAT_B), .CNT_W(CNT_B)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       mul;
        logic       br;
        logic       mr;
        logic [4:0] ex_rt;
        logic       hold;
        logic       flush;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic mul, input logic br, input logic mr, input logic [4:0] ex_rt);
        bus_a.ID_Rs_In = rs;          bus_b.ID_Rs_In = rs;
        bus_a.ID_Rt_In = rt;          bus_b.ID_Rt_In = rt;
        bus_a.ID_UsesRt_In = uses;    bus_b.ID_UsesRt_In = uses;
        bus_a.ID_MulStart_In = mul;   bus_b.ID_MulStart_In = mul;
        bus_a.ID_BranchTaken_In = br; bus_b.ID_BranchTaken_In = br;
        bus_a.EX_MemRead_In = mr;     bus_b.EX_MemRead_In = mr;
        bus_a.EX_Rt_In = ex_rt;       bus_b.EX_Rt_In = ex_rt;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    // {IF/ID hold, PC hold, bubble, flush, busy}
    task automatic chk_a(input string name, input logic h, input logic f, input logic b);
        check(name, {27'd0, bus_a.IF_IDWrite_Out, bus_a.PCWrite_Out, bus_a.ID_EX_Bubble_Out,
                     bus_a.IF_Flush_Out, bus_a.Busy_Out}, {27'd0, h, h, h, f, b});
    endtask

    task automatic chk_b(input string name, input logic h, input logic f, input logic b);
        check(name, {27'd0, bus_b.IF_IDWrite_Out, bus_b.PCWrite_Out, bus_b.ID_EX_Bubble_Out,
                     bus_b.IF_Flush_Out, bus_b.Busy_Out}, {27'd0, h, h, h, f, b});
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Advance to the next drive point (falling edge).
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int exp_cnt;
        int left_a, left_b;
        longint cnt_a, cnt_b;

        // Reset raised between clock edges must clear everything at once.
        idle();
        #2 reset = 1'b1;
        #1;
        chk_a("reset_outputs_a", 1'b0, 1'b0, 1'b0);
        chk_b("reset_outputs_b", 1'b0, 1'b0, 1'b0);
        check("reset_count_a", bus_a.Stall_Count_Out, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table of single-cycle S_RUN vectors.
        vecs.push_back('{rs:8,  rt:0,  uses:0, mul:0, br:0, mr:1, ex_rt:8,  hold:1, flush:0});
        vecs.push_back('{rs:8,  rt:0,  uses:0, mul:0, br:0, mr:0, ex_rt:8,  hold:0, flush:0});
        vecs.push_back('{rs:0,  rt:0,  uses:1, mul:0, br:0, mr:1, ex_rt:0,  hold:0, flush:0});
        vecs.push_back('{rs:1,  rt:9,  uses:0, mul:0, br:0, mr:1, ex_rt:9,  hold:0, flush:0});
        vecs.push_back('{rs:1,  rt:9,  uses:1, mul:0, br:0, mr:1, ex_rt:9,  hold:1, flush:0});
        vecs.push_back('{rs:2,  rt:3,  uses:1, mul:0, br:1, mr:0, ex_rt:0,  hold:0, flush:1});
        vecs.push_back('{rs:5,  rt:0,  uses:0, mul:0, br:1, mr:1, ex_rt:5,  hold:1, flush:0});
        vecs.push_back('{rs:7,  rt:0,  uses:0, mul:1, br:0, mr:1, ex_rt:7,  hold:1, flush:0});
        vecs.push_back('{rs:7,  rt:0,  uses:0, mul:0, br:0, mr:0, ex_rt:7,  hold:0, flush:0});
        vecs.push_back('{rs:30, rt:31, uses:1, mul:0, br:0, mr:1, ex_rt:31, hold:1, flush:0});
        vecs.push_back('{rs:4,  rt:5,  uses:1, mul:0, br:0, mr:1, ex_rt:3,  hold:0, flush:0});

        exp_cnt = 0;
        foreach (vecs[i]) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].uses, vecs[i].mul, vecs[i].br,
                  vecs[i].mr, vecs[i].ex_rt);
            #2;
            chk_a($sformatf("vec%0d", i), vecs[i].hold, vecs[i].flush, 1'b0);
            if (vecs[i].hold) exp_cnt++;
            next_cycle();
        end
        idle();
        #2;
        chk_a("table_no_mul_started", 1'b0, 1'b0, 1'b0);
        check("table_stall_count", bus_a.Stall_Count_Out, exp_cnt);

        // Load-use: exactly one stall cycle.
        do_reset();
        drive(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
        #2 chk_a("lu_stall", 1'b1, 1'b0, 1'b0);
        next_cycle();
        idle();
        #2 chk_a("lu_release", 1'b0, 1'b0, 1'b0);
        check("lu_count", bus_a.Stall_Count_Out, 32'd1);

        // Multiply: no stall at issue, then LAT_A-1 busy stall cycles.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        #2 chk_a("mul_issue", 1'b0, 1'b0, 1'b0);
        next_cycle();
        idle();
        for (int k = 0; k < LAT_A - 1; k++) begin
            #2 chk_a($sformatf("mul_busy%0d", k), 1'b1, 1'b0, 1'b1);
            next_cycle();
        end
        #2 chk_a("mul_release", 1'b0, 1'b0, 1'b0);
        check("mul_count", bus_a.Stall_Count_Out, LAT_A - 1);

        // Branch in S_RUN flushes for one cycle.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        #2 chk_a("br_flush", 1'b0, 1'b1, 1'b0);
        next_cycle();
        idle();
        #2 chk_a("br_flush_end", 1'b0, 1'b0, 1'b0);

        // Branch held across a multiply flushes on the first S_RUN cycle.
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        #2 chk_a("brmul_issue", 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        for (int k = 0; k < LAT_A - 1; k++) begin
            #2 chk_a($sformatf("brmul_suppress%0d", k), 1'b1, 1'b0, 1'b1);
            next_cycle();
        end
        #2 chk_a("brmul_flush", 1'b0, 1'b1, 1'b0);
        next_cycle();
        idle();

        // Reset during the second S_MUL cycle aborts the occupancy.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        next_cycle();
        idle();
        #2 chk_a("rstmul_first", 1'b1, 1'b0, 1'b1);
        next_cycle();
        #2 chk_a("rstmul_second", 1'b1, 1'b0, 1'b1);
        check("rstmul_count_before", bus_a.Stall_Count_Out, 32'd1);
        #1 reset = 1'b1;
        #1 chk_a("rstmul_abort", 1'b0, 1'b0, 1'b0);
        check("rstmul_count_cleared", bus_a.Stall_Count_Out, 32'd0);
        next_cycle();
        reset = 1'b0;
        #2 chk_a("rstmul_run", 1'b0, 1'b0, 1'b0);
        next_cycle();
        #2 chk_a("rstmul_run2", 1'b0, 1'b0, 1'b0);

        // MUL_LAT = 2 gives a single stall cycle.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        #2 chk_b("lat2_issue", 1'b0, 1'b0, 1'b0);
        next_cycle();
        idle();
        #2 chk_b("lat2_busy", 1'b1, 1'b0, 1'b1);
        next_cycle();
        #2 chk_b("lat2_release", 1'b0, 1'b0, 1'b0);

        // Saturation on the 2-bit counter: reach all-ones minus 1, then hold.
        do_reset();
        drive(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
        next_cycle();
        next_cycle();
        #2 check("sat_pre", {30'd0, bus_b.Stall_Count_Out}, 32'd2);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            #2 check($sformatf("sat_hold%0d", k), {30'd0, bus_b.Stall_Count_Out}, 32'd3);
        end

        // Randomised run against a cycle-counting reference model.
        do_reset();
        left_a = 0; left_b = 0; cnt_a = 0; cnt_b = 0;
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rs, rt, ex;
            logic uses, mul, br, mr, lu, st_a, st_b;
            rs   = 5'($urandom_range(0, 3));
            rt   = 5'($urandom_range(0, 3));
            ex   = 5'($urandom_range(0, 3));
            uses = 1'($urandom_range(0, 1));
            mul  = ($urandom_range(0, 5) == 0);
            br   = ($urandom_range(0, 2) == 0);
            mr   = 1'($urandom_range(0, 1));
            drive(rs, rt, uses, mul, br, mr, ex);
            lu   = mr && (ex != 0) && ((ex == rs) || (uses && (ex == rt)));
            st_a = (left_a > 0) || lu;
            st_b = (left_b > 0) || lu;
            #2;
            chk_a($sformatf("rnd%0d_a", n), st_a, !st_a && br, left_a > 0);
            chk_b($sformatf("rnd%0d_b", n), st_b, !st_b && br, left_b > 0);
            check($sformatf("rnd%0d_cnt_a", n), bus_a.Stall_Count_Out, 32'(cnt_a));
            check($sformatf("rnd%0d_cnt_b", n), {30'd0, bus_b.Stall_Count_Out}, 32'(cnt_b));
            // Effect of the coming rising edge.
            if (st_a && cnt_a < (64'd1 << CNT_A) - 1) cnt_a++;
            if (st_b && cnt_b < (64'd1 << CNT_B) - 1) cnt_b++;
            if (left_a > 0) left_a--;
            else if (!lu && mul) left_a = LAT_A - 1;
            if (left_b > 0) left_b--;
            else if (!lu && mul) left_b = LAT_B - 1;
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Hazard and stall controller driving the IF/ID pipeline register's write-hold input, the PC write enable, the ID/EX bubble and the IF flush.
- Detects load-use hazards between the ID and EX stages.
- Holds the front end for the occupancy of multi-cycle multiply instructions.
- Flushes IF on a branch resolved taken in ID.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
- MUL_LAT, 4, cycles a multiply occupies EX (legal range 2..16); the front end stalls MUL_LAT-1 cycles.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- ID_Rs_In  input  5  rs field of the instruction in ID.
- ID_Rt_In  input  5  rt field of the instruction in ID.
- ID_UsesRt_In  input  1  1 = the ID instruction reads rt as a source.
- ID_MulStart_In  input  1  1 = the ID instruction is a multi-cycle multiply.
- ID_BranchTaken_In  input  1  1 = the branch in ID resolved taken.
- EX_MemRead_In  input  1  1 = the instruction in EX is a load.
- EX_Rt_In  input  5  destination register of the load in EX.
- IF_IDWrite_Out  output  1  0 = IF/ID loads; 1 = IF/ID holds PC and bubbles the instruction.
- PCWrite_Out  output  1  0 = PC updates; 1 = PC holds.
- ID_EX_Bubble_Out  output  1  1 = ID/EX control fields zeroed this cycle.
- IF_Flush_Out  output  1  1 = discard the instruction being fetched.
- Busy_Out  output  1  1 = multiply occupancy in progress.
- Stall_Count_Out  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Single clock domain.
- Reset is asynchronous, active-high, and clears all state immediately. Reset values:
  - state = S_RUN, mul_cnt = 0, Stall_Count_Out = 0.
  - Outputs resolve to IF_IDWrite_Out = 0, PCWrite_Out = 0, ID_EX_Bubble_Out = 0, IF_Flush_Out = 0, Busy_Out = 0.
- Control outputs are combinational from registered state and current inputs, with zero latency: a hazard is acted on in the same cycle it is visible.
- lu (load-use) = EX_MemRead_In & (EX_Rt_In != 0) & ((EX_Rt_In == ID_Rs_In) | (ID_UsesRt_In & (EX_Rt_In == ID_Rt_In))).
- A register-0 destination never causes a stall.
- stall = (state == S_MUL) | lu. When stall = 1: IF_IDWrite_Out = 1, PCWrite_Out = 1, ID_EX_Bubble_Out = 1.
- States:
  - S_RUN:
    - lu = 1: stall this cycle and remain in S_RUN. A load occupies EX for one cycle only, so the stall is exactly one cycle.
    - lu = 0 and ID_MulStart_In = 1: no stall this cycle (the multiply advances to EX). Go to S_MUL with mul_cnt = MUL_LAT-2.
    - lu = 0 and ID_BranchTaken_In = 1: IF_Flush_Out = 1.
    - Multiply start and taken branch in the same cycle: both take effect.
  - S_MUL:
    - Busy_Out = 1, stall = 1.
    - mul_cnt = 0: return to S_RUN next edge. Otherwise decrement mul_cnt.
    - Total stall cycles = MUL_LAT-1.
- Priority: reset > S_MUL occupancy > lu > multiply start / branch flush.
- While stall = 1:
  - IF_Flush_Out is forced to 0, because the branch is re-evaluated once the pipeline advances.
  - ID_MulStart_In is ignored; a multiply held in ID starts only on a non-stall cycle.
- Back-to-back multiplies: the second starts on the first S_RUN cycle after the first finishes, giving a 0-cycle gap at the S_RUN boundary.
- A load-use hazard still present on exit from S_MUL produces one further stall cycle in S_RUN.
- Stall_Count_Out increments by 1 on each rising edge where stall = 1 and saturates at all-ones without wrapping.
- Reset mid-S_MUL aborts the occupancy. The next cycle is S_RUN with all stalls released.
- mul_cnt width is 4 bits; MUL_LAT outside 2..16 is illegal and covered by an elaboration-time check.

Decomposition:
- Shared pipeline package holds:
  - state encoding S_RUN = 1'b0, S_MUL = 1'b1.
  - register-index width constant REG_W = 5.
  - write-hold polarity constants WR_LOAD = 0, WR_HOLD = 1, shared with the IF/ID and PC registers.
- One natural sub-module: sat_counter (parameterised width, enable, async reset) for Stall_Count_Out.
- The hazard comparator stays inline.

Test Plan:
- Reset asserted mid-cycle with no clock edge -> all outputs 0, Stall_Count_Out = 0 immediately.
- EX_MemRead_In = 1, EX_Rt_In = 8, ID_Rs_In = 8 -> one cycle with IF_IDWrite_Out = 1, PCWrite_Out = 1, ID_EX_Bubble_Out = 1; next cycle (EX_MemRead_In = 0) all 0; Stall_Count_Out = 1.
- EX_Rt_In = 0 with ID_Rs_In = 0, EX_MemRead_In = 1 -> no stall. EX_Rt_In = 9 with ID_Rt_In = 9 and ID_UsesRt_In = 0 -> no stall.
- ID_MulStart_In pulse with MUL_LAT = 4 -> 0 stall cycles at issue, then exactly 3 stall cycles with Busy_Out = 1, then release; Stall_Count_Out = 3.
- ID_BranchTaken_In = 1 in S_RUN -> IF_Flush_Out = 1 for one cycle. Branch asserted during S_MUL -> IF_Flush_Out = 0 until S_RUN; with the branch held, the flush occurs on the first S_RUN cycle.
- Reset asserted in the 2nd S_MUL cycle -> Busy_Out = 0 and stalls released immediately; force the counter to all-ones minus 1, apply 3 stall cycles -> holds at all-ones.
